// File: rtl/baopoco_quant_gain_ctrl.sv
// Double-buffered quantiser gain table update sequencer: toggle-bit register writes into the shadow bank,
// commits swap the live bank on spectrum sync. Optional bulk fill is enabled by defining QUANT_GAIN_FILL_EN.
module baopoco_quant_gain_ctrl #(
    parameter int ADDR_W = 10,
    parameter int GAIN_W = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       reg_data,
    input  logic              sync_in,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [GAIN_W-1:0] ram_din,
    output logic              bank_sel,
    output logic              commit_pending,
    output logic              busy,
    output logic              err,
    output logic [15:0]       swap_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ARM   = 2'd2
`ifdef QUANT_GAIN_FILL_EN
        , FILL = 2'd3
`endif
    } state_t;

    state_t              state_r;
    logic                prev_wr_r;
    logic                prev_cm_r;
    logic                held_wr_r;
    logic                held_cm_r;
    logic [ADDR_W-1:0]   held_addr_r;
    logic [GAIN_W-1:0]   held_gain_r;
    logic                wr_ev_s;
    logic                cm_ev_s;
    logic                idle_s;
    logic [ADDR_W-1:0]   ev_addr_s;
    logic [GAIN_W-1:0]   ev_gain_s;
    logic [ADDR_W-1:0]   src_addr_s;
    logic [GAIN_W-1:0]   src_gain_s;
    logic                start_wr_s;
    logic                start_arm_s;
    logic                take_wr_s;
    logic                park_wr_s;
    logic                wr_full_s;
    logic                park_cm_s;
    logic                drop_s;
    logic                unused_s;
`ifdef QUANT_GAIN_FILL_EN
    logic                held_fill_r;
    logic                ev_fill_s;
    logic                src_fill_s;
    assign ev_fill_s = reg_data[29];
`endif

    assign wr_ev_s   = reg_data[31] ^ prev_wr_r;
    assign cm_ev_s   = reg_data[30] ^ prev_cm_r;
    assign ev_addr_s = reg_data[16 +: ADDR_W];
    assign ev_gain_s = reg_data[GAIN_W-1:0];
    assign idle_s    = (state_r == IDLE);
    assign unused_s  = ^reg_data;

    // A parked write always wins over a fresh event; the fresh one then takes the freed slot.
    assign start_wr_s  = idle_s && (held_wr_r || wr_ev_s);
    assign start_arm_s = idle_s && !start_wr_s && (held_cm_r || cm_ev_s);
    assign take_wr_s   = idle_s && held_wr_r;
    assign park_wr_s   = wr_ev_s && !(idle_s && !held_wr_r);
    assign wr_full_s   = held_wr_r && !take_wr_s;
    assign park_cm_s   = cm_ev_s && (state_r != ARM) && !start_arm_s;
    assign drop_s      = (park_wr_s && wr_full_s) || (park_cm_s && held_cm_r);

    // Select write source: the held slot if occupied, else the live event fields.
    always_comb begin
        src_addr_s = ev_addr_s;
        src_gain_s = ev_gain_s;
`ifdef QUANT_GAIN_FILL_EN
        src_fill_s = ev_fill_s;
`endif
        if (held_wr_r) begin
            src_addr_s = held_addr_r;
            src_gain_s = held_gain_r;
`ifdef QUANT_GAIN_FILL_EN
            src_fill_s = held_fill_r;
`endif
        end else begin
            src_addr_s = ev_addr_s;
            src_gain_s = ev_gain_s;
`ifdef QUANT_GAIN_FILL_EN
            src_fill_s = ev_fill_s;
`endif
        end
    end

    // Control FSM with registered RAM port, status outputs and event slots.
    always_ff @(posedge user_clk) begin
        prev_wr_r <= reg_data[31];
        prev_cm_r <= reg_data[30];
        if (!user_rst_n) begin
            state_r        <= IDLE;
            held_wr_r      <= 1'b0;
            held_cm_r      <= 1'b0;
            held_addr_r    <= {ADDR_W{1'b0}};
            held_gain_r    <= {GAIN_W{1'b0}};
`ifdef QUANT_GAIN_FILL_EN
            held_fill_r    <= 1'b0;
`endif
            ram_we         <= 1'b0;
            ram_addr       <= {(ADDR_W+1){1'b0}};
            ram_din        <= {GAIN_W{1'b0}};
            bank_sel       <= 1'b0;
            commit_pending <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
            swap_cnt       <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_wr_s) begin
                        ram_we   <= 1'b1;
                        busy     <= 1'b1;
                        ram_din  <= src_gain_s;
`ifdef QUANT_GAIN_FILL_EN
                        if (src_fill_s) begin
                            state_r  <= FILL;
                            ram_addr <= {~bank_sel, {ADDR_W{1'b0}}};
                        end else begin
                            state_r  <= WRITE;
                            ram_addr <= {~bank_sel, src_addr_s};
                        end
`else
                        state_r  <= WRITE;
                        ram_addr <= {~bank_sel, src_addr_s};
`endif
                    end else if (start_arm_s) begin
                        state_r        <= ARM;
                        commit_pending <= 1'b1;
                    end
                end
                WRITE: begin
                    state_r <= IDLE;
                    ram_we  <= 1'b0;
                    busy    <= 1'b0;
                end
`ifdef QUANT_GAIN_FILL_EN
                FILL: begin
                    if (ram_addr[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
                        state_r <= IDLE;
                        ram_we  <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        ram_addr <= ram_addr + {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
`endif
                ARM: begin
                    if (sync_in) begin
                        state_r        <= IDLE;
                        bank_sel       <= ~bank_sel;
                        swap_cnt       <= swap_cnt + 16'd1;
                        commit_pending <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    ram_we         <= 1'b0;
                    busy           <= 1'b0;
                    commit_pending <= 1'b0;
                end
            endcase

            if (park_wr_s && !wr_full_s) begin
                held_wr_r   <= 1'b1;
                held_addr_r <= ev_addr_s;
                held_gain_r <= ev_gain_s;
`ifdef QUANT_GAIN_FILL_EN
                held_fill_r <= ev_fill_s;
`endif
            end else if (take_wr_s) begin
                held_wr_r <= 1'b0;
            end

            if (start_arm_s) begin
                held_cm_r <= 1'b0;
            end else if (park_cm_s) begin
                held_cm_r <= 1'b1;
            end

            if (drop_s) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_baopoco_quant_gain_ctrl.sv
// Directed self-checking bench for baopoco_quant_gain_ctrl (ADDR_W=10, GAIN_W=16).
module tb_baopoco_quant_gain_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] reg_data;
    logic        sync_in;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [15:0] ram_din;
    logic        bank_sel;
    logic        commit_pending;
    logic        busy;
    logic        err;
    logic [15:0] swap_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    baopoco_quant_gain_ctrl #(.ADDR_W(10), .GAIN_W(16)) dut (
        .user_clk       (clk),
        .user_rst_n     (rst_n),
        .reg_data       (reg_data),
        .sync_in        (sync_in),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .bank_sel       (bank_sel),
        .commit_pending (commit_pending),
        .busy           (busy),
        .err            (err),
        .swap_cnt       (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_we"}, {31'd0, ram_we}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sync_in  = 1'b0;
        reg_data = 32'hC000_0000;

        // 1: toggle bits held high through reset must not fire on release
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("rst_release");
            check_eq("rst_pending", {31'd0, commit_pending}, 32'd0);
            check_eq("rst_err", {31'd0, err}, 32'd0);
        end
        check_eq("rst_bank", {31'd0, bank_sel}, 32'd0);
        check_eq("rst_swap", {16'd0, swap_cnt}, 32'd0);

        // re-reset with the register at zero so the following vectors match their stated form
        reg_data = 32'h0000_0000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 2: single write, one-cycle latency, one-cycle pulse
        reg_data = 32'h8005_1234;
        tick();
        check_eq("wr_we", {31'd0, ram_we}, 32'd1);
        check_eq("wr_addr", {21'd0, ram_addr}, 32'h405);
        check_eq("wr_din", {16'd0, ram_din}, 32'h1234);
        check_eq("wr_busy", {31'd0, busy}, 32'd1);
        tick();
        check_quiet("wr_end");

        // 3: sync without commit is ignored
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check_eq("stray_sync_bank", {31'd0, bank_sel}, 32'd0);
        check_eq("stray_sync_swap", {16'd0, swap_cnt}, 32'd0);

        // 3: commit waits for sync, then swaps
        reg_data = 32'hC005_1234;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("arm_pending", {31'd0, commit_pending}, 32'd1);
            check_eq("arm_bank", {31'd0, bank_sel}, 32'd0);
            check_eq("arm_we", {31'd0, ram_we}, 32'd0);
        end
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check_eq("swap1_bank", {31'd0, bank_sel}, 32'd1);
        check_eq("swap1_cnt", {16'd0, swap_cnt}, 32'd1);
        check_eq("swap1_pending", {31'd0, commit_pending}, 32'd0);

        // 4: simultaneous write+commit; shadow is now bank 0
        reg_data = 32'h0003_00AA;
        tick();
        check_eq("both_we", {31'd0, ram_we}, 32'd1);
        check_eq("both_addr", {21'd0, ram_addr}, 32'h003);
        check_eq("both_din", {16'd0, ram_din}, 32'h00AA);
        check_eq("both_pending0", {31'd0, commit_pending}, 32'd0);
        tick();
        check_quiet("both_idle");
        tick();
        check_eq("both_armed", {31'd0, commit_pending}, 32'd1);
        reg_data = 32'h4003_00AA;
        tick();
        check_eq("cm_in_arm_err", {31'd0, err}, 32'd0);
        check_eq("cm_in_arm_pending", {31'd0, commit_pending}, 32'd1);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check_eq("swap2_bank", {31'd0, bank_sel}, 32'd0);
        check_eq("swap2_cnt", {16'd0, swap_cnt}, 32'd2);

        // writes in ARM: first is held, second is dropped
        reg_data = 32'h0003_00AA;
        tick();
        check_eq("arm3_pending", {31'd0, commit_pending}, 32'd1);
        reg_data = 32'h8007_0011;
        tick();
        check_eq("held_no_we", {31'd0, ram_we}, 32'd0);
        check_eq("held_no_err", {31'd0, err}, 32'd0);
        reg_data = 32'h0008_0022;
        tick();
        check_eq("drop_err", {31'd0, err}, 32'd1);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check_eq("swap3_bank", {31'd0, bank_sel}, 32'd1);
        check_eq("swap3_cnt", {16'd0, swap_cnt}, 32'd3);
        tick();
        check_eq("held_we", {31'd0, ram_we}, 32'd1);
        check_eq("held_addr", {21'd0, ram_addr}, 32'h007);
        check_eq("held_din", {16'd0, ram_din}, 32'h0011);
        tick();
        check_quiet("held_end");
        check_eq("err_sticky", {31'd0, err}, 32'd1);

        // reset in the middle of a write
        reg_data = 32'h8009_0033;
        tick();
        check_eq("pre_rst_we", {31'd0, ram_we}, 32'd1);
        check_eq("pre_rst_addr", {21'd0, ram_addr}, 32'h009);
        rst_n = 1'b0;
        tick();
        check_quiet("midwr_rst");
        check_eq("midwr_rst_bank", {31'd0, bank_sel}, 32'd0);
        check_eq("midwr_rst_swap", {16'd0, swap_cnt}, 32'd0);
        check_eq("midwr_rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("midwr_post");
        end

`ifdef QUANT_GAIN_FILL_EN
        // 5: fill 1024 entries; one write during fill is held, the next one is dropped
        reg_data = 32'h2000_00FF;
        tick();
        check_eq("fill0_we", {31'd0, ram_we}, 32'd1);
        check_eq("fill0_addr", {21'd0, ram_addr}, 32'h400);
        check_eq("fill0_din", {16'd0, ram_din}, 32'h00FF);
        for (int i = 1; i < 1024; i++) begin
            if (i == 100) reg_data = 32'h8001_0055;
            if (i == 200) reg_data = 32'h0002_0066;
            tick();
            check_eq("fill_we", {31'd0, ram_we}, 32'd1);
            check_eq("fill_addr", {21'd0, ram_addr}, 32'h400 + i);
            check_eq("fill_busy", {31'd0, busy}, 32'd1);
        end
        check_eq("fill_drop_err", {31'd0, err}, 32'd1);
        tick();
        check_quiet("fill_done");
        tick();
        check_eq("fill_held_we", {31'd0, ram_we}, 32'd1);
        check_eq("fill_held_addr", {21'd0, ram_addr}, 32'h401);
        check_eq("fill_held_din", {16'd0, ram_din}, 32'h0055);
        tick();

        // 6: reset mid-fill at 0x500
        reg_data = 32'hA000_00FF;
        tick();
        for (int i = 1; i <= 256; i++) begin
            tick();
        end
        check_eq("fill_at_500", {21'd0, ram_addr}, 32'h500);
        rst_n = 1'b0;
        tick();
        check_quiet("midfill_rst");
        check_eq("midfill_rst_bank", {31'd0, bank_sel}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_quiet("midfill_post");
        end
`else
        // without fill support, bit 29 is ignored and a single write happens
        reg_data = 32'h2004_00FF;
        tick();
        check_eq("nofill_we", {31'd0, ram_we}, 32'd1);
        check_eq("nofill_addr", {21'd0, ram_addr}, 32'h404);
        tick();
        check_quiet("nofill_single");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
